// File: rtl/regs_scb.sv
// regs_scb: signed register file with two combinational read ports, a fast write
// port, a writeback port, a per-register busy scoreboard and a busy counter.
// Optional feature macro: REGS_BYPASS_EN (forward same-cycle writes to the read ports).
module regs_scb #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned NREGS  = 11,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rsn,
    input  logic [ADDR_W-1:0]        i_reg0,
    input  logic [ADDR_W-1:0]        i_reg1,
    output logic signed [DATA_W-1:0] o_data0,
    output logic signed [DATA_W-1:0] o_data1,
    output logic                     o_rdy0,
    output logic                     o_rdy1,
    input  logic [ADDR_W-1:0]        i_reg2,
    input  logic signed [DATA_W-1:0] i_data2,
    input  logic [ADDR_W-1:0]        i_reg3,
    input  logic signed [DATA_W-1:0] i_data3,
    input  logic [ADDR_W-1:0]        i_lock,
    output logic                     o_wr_err,
    output logic [ADDR_W-1:0]        o_busy_cnt
);

    logic signed [DATA_W-1:0] rrr [1:NREGS];
    logic [NREGS:1]           busy;
    logic [NREGS:1]           busy_nxt;
    logic                     v2;
    logic                     v3;
    logic                     vl;
    logic                     busy2;
    logic                     busyl;
    logic                     acc2;
    logic                     err_nxt;
    logic [ADDR_W-1:0]        cnt_nxt;

    // Classify write/lock addresses, sample pre-edge busy, decide acceptance and errors
    always_comb begin
        v2    = (i_reg2 != '0) && (i_reg2 <= ADDR_W'(NREGS));
        v3    = (i_reg3 != '0) && (i_reg3 <= ADDR_W'(NREGS));
        vl    = (i_lock != '0) && (i_lock <= ADDR_W'(NREGS));
        busy2 = 1'b0;
        busyl = 1'b0;
        for (int i = 1; i <= int'(NREGS); i++) begin
            if (i_reg2 == ADDR_W'(i)) busy2 = busy[i];
            if (i_lock == ADDR_W'(i)) busyl = busy[i];
        end
        // A fast write loses to a pending writeback and to a same-cycle writeback
        acc2    = v2 && !busy2 && !(v3 && (i_reg3 == i_reg2));
        err_nxt = (v2 && !acc2) || (vl && busyl && !(v3 && (i_reg3 == i_lock)));
    end

    // Next busy vector: writeback clears, a same-cycle lock wins; count is its popcount
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = '0;
        for (int i = 1; i <= int'(NREGS); i++) begin
            if (i_reg3 == ADDR_W'(i)) busy_nxt[i] = 1'b0;
            if (i_lock == ADDR_W'(i)) busy_nxt[i] = 1'b1;
            cnt_nxt = cnt_nxt + ADDR_W'(busy_nxt[i]);
        end
    end

    // Scoreboard, error pulse and busy counter
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            busy       <= '0;
            o_wr_err   <= 1'b0;
            o_busy_cnt <= '0;
        end else begin
            busy       <= busy_nxt;
            o_wr_err   <= err_nxt;
            o_busy_cnt <= cnt_nxt;
        end
    end

    // Register storage; writeback has priority over the fast port
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            for (int i = 1; i <= int'(NREGS); i++) rrr[i] <= '0;
        end else begin
            for (int i = 1; i <= int'(NREGS); i++) begin
                if (i_reg3 == ADDR_W'(i)) begin
                    rrr[i] <= i_data3;
                end else if (acc2 && (i_reg2 == ADDR_W'(i))) begin
                    rrr[i] <= i_data2;
                end
            end
        end
    end

    // Read ports; null addresses read 0 and ready
    always_comb begin
        o_data0 = '0;
        o_rdy0  = 1'b1;
        o_data1 = '0;
        o_rdy1  = 1'b1;
        for (int i = 1; i <= int'(NREGS); i++) begin
            if (i_reg0 == ADDR_W'(i)) begin
                o_data0 = rrr[i];
                o_rdy0  = !busy[i];
            end
            if (i_reg1 == ADDR_W'(i)) begin
                o_data1 = rrr[i];
                o_rdy1  = !busy[i];
            end
        end
`ifdef REGS_BYPASS_EN
        if (v3 && (i_reg0 == i_reg3)) begin
            o_data0 = i_data3;
            o_rdy0  = (i_lock != i_reg3);
        end else if (acc2 && (i_reg0 == i_reg2)) begin
            o_data0 = i_data2;
        end
        if (v3 && (i_reg1 == i_reg3)) begin
            o_data1 = i_data3;
            o_rdy1  = (i_lock != i_reg3);
        end else if (acc2 && (i_reg1 == i_reg2)) begin
            o_data1 = i_data2;
        end
`endif
    end

endmodule

// File: tb/tb_regs_scb.sv
// tb_regs_scb: randomized and directed checks of regs_scb against a behavioural model.
module tb_regs_scb;

    logic              i_clk;
    logic              i_rsn;
    logic [3:0]        i_reg0;
    logic [3:0]        i_reg1;
    logic signed [5:0] o_data0;
    logic signed [5:0] o_data1;
    logic              o_rdy0;
    logic              o_rdy1;
    logic [3:0]        i_reg2;
    logic signed [5:0] i_data2;
    logic [3:0]        i_reg3;
    logic signed [5:0] i_data3;
    logic [3:0]        i_lock;
    logic              o_wr_err;
    logic [3:0]        o_busy_cnt;

    int total = 0;
    int bad   = 0;

    // Behavioural model: register values, busy flags, expected registered outputs
    int mem [16];
    bit bsy [16];
    bit exp_err;
    int exp_cnt;

    regs_scb dut (
        .i_clk(i_clk), .i_rsn(i_rsn),
        .i_reg0(i_reg0), .i_reg1(i_reg1),
        .o_data0(o_data0), .o_data1(o_data1),
        .o_rdy0(o_rdy0), .o_rdy1(o_rdy1),
        .i_reg2(i_reg2), .i_data2(i_data2),
        .i_reg3(i_reg3), .i_data3(i_data3),
        .i_lock(i_lock),
        .o_wr_err(o_wr_err), .o_busy_cnt(o_busy_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic bit valid(input int a);
        return (a >= 1) && (a <= 11);
    endfunction

    function automatic bit fast_accepted();
        int a2 = int'(i_reg2);
        int a3 = int'(i_reg3);
        return valid(a2) && !bsy[a2] && !(valid(a3) && a3 == a2);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            mem[i] = 0;
            bsy[i] = 1'b0;
        end
        exp_err = 1'b0;
        exp_cnt = 0;
    endfunction

    // Apply one clock edge's worth of spec rules to the model, using the current inputs
    function automatic void model_edge();
        int  a2  = int'(i_reg2);
        int  a3  = int'(i_reg3);
        int  al  = int'(i_lock);
        bit  acc = fast_accepted();
        exp_err = 1'b0;
        if (valid(a2) && !acc) exp_err = 1'b1;
        if (valid(al) && bsy[al] && !(valid(a3) && a3 == al)) exp_err = 1'b1;
        if (valid(a3)) mem[a3] = int'(i_data3);
        if (acc) mem[a2] = int'(i_data2);
        if (valid(a3)) bsy[a3] = 1'b0;
        if (valid(al)) bsy[al] = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 16; i++) exp_cnt += int'(bsy[i]);
    endfunction

    // Expected combinational read of address a given the model and the current inputs
    function automatic void exp_read(input int a, output logic signed [5:0] d, output logic r);
        d = valid(a) ? 6'(mem[a]) : 6'(0);
        r = valid(a) ? !bsy[a] : 1'b1;
`ifdef REGS_BYPASS_EN
        if (valid(a) && a == int'(i_reg3)) begin
            d = i_data3;
            r = (int'(i_lock) != a);
        end else if (valid(a) && a == int'(i_reg2) && fast_accepted()) begin
            d = i_data2;
        end
`endif
    endfunction

    task automatic idle();
        i_reg2  = '0;
        i_data2 = '0;
        i_reg3  = '0;
        i_data3 = '0;
        i_lock  = '0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic signed [5:0] ed;
        logic              er;
        i_rsn = 1'b0;
        idle();
        model_reset();
        #2;
        for (int a = 0; a < 16; a++) begin
            i_reg0 = 4'(a);
            i_reg1 = 4'(15 - a);
            #1;
            exp_read(a, ed, er);
            total++;
            if (o_data0 !== ed || o_rdy0 !== er) begin
                bad++;
                $display("FAIL reset_rd0 a=%0d got d=%0d r=%0b exp d=%0d r=%0b", a, o_data0, o_rdy0, ed, er);
            end
            exp_read(15 - a, ed, er);
            total++;
            if (o_data1 !== ed || o_rdy1 !== er) begin
                bad++;
                $display("FAIL reset_rd1 a=%0d got d=%0d r=%0b exp d=%0d r=%0b", 15 - a, o_data1, o_rdy1, ed, er);
            end
        end
        total++;
        if (o_busy_cnt !== 4'd0 || o_wr_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_regs got cnt=%0d err=%0b exp cnt=0 err=0", o_busy_cnt, o_wr_err);
        end
        @(negedge i_clk);
        i_rsn = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_fast_write();
        logic signed [5:0] ed;
        logic              er;
        i_reg2 = 4'd5;
        i_data2 = 6'(-7);
        tick();
        idle();
        i_reg0 = 4'd5;
        #1;
        exp_read(5, ed, er);
        total++;
        if (o_data0 !== ed || ed !== 6'(-7) || o_wr_err !== exp_err) begin
            bad++;
            $display("FAIL fast_wr5 got d=%0d err=%0b exp d=-7 err=%0b", o_data0, o_wr_err, exp_err);
        end
        i_reg2 = 4'd12;
        i_data2 = 6'd13;
        tick();
        idle();
        i_reg1 = 4'd12;
        #1;
        total++;
        if (o_data1 !== 6'sd0 || o_rdy1 !== 1'b1 || o_wr_err !== 1'b0) begin
            bad++;
            $display("FAIL fast_wr12 got d=%0d r=%0b err=%0b exp d=0 r=1 err=0", o_data1, o_rdy1, o_wr_err);
        end
    endtask

    task automatic test_lock();
        logic signed [5:0] ed;
        logic              er;
        i_lock = 4'd3;
        tick();
        idle();
        i_reg0 = 4'd3;
        #1;
        exp_read(3, ed, er);
        total++;
        if (o_rdy0 !== er || o_busy_cnt !== 4'(exp_cnt)) begin
            bad++;
            $display("FAIL lock3 got r=%0b cnt=%0d exp r=%0b cnt=%0d", o_rdy0, o_busy_cnt, er, exp_cnt);
        end
        i_reg2 = 4'd3;
        i_data2 = 6'd10;
        tick();
        idle();
        #1;
        exp_read(3, ed, er);
        total++;
        if (o_wr_err !== exp_err || o_data0 !== ed) begin
            bad++;
            $display("FAIL waw3 got err=%0b d=%0d exp err=%0b d=%0d", o_wr_err, o_data0, exp_err, ed);
        end
        tick();
        total++;
        if (o_wr_err !== exp_err) begin
            bad++;
            $display("FAIL err_pulse got %0b exp %0b", o_wr_err, exp_err);
        end
        i_reg3 = 4'd3;
        i_data3 = 6'd31;
        tick();
        idle();
        #1;
        exp_read(3, ed, er);
        total++;
        if (o_data0 !== ed || o_rdy0 !== er || o_busy_cnt !== 4'(exp_cnt)) begin
            bad++;
            $display("FAIL wb3 got d=%0d r=%0b cnt=%0d exp d=%0d r=%0b cnt=%0d", o_data0, o_rdy0, o_busy_cnt, ed, er, exp_cnt);
        end
    endtask

    task automatic test_conflict();
        logic signed [5:0] ed;
        logic              er;
        i_reg2 = 4'd7;
        i_data2 = 6'd4;
        i_reg3 = 4'd7;
        i_data3 = 6'(-32);
        tick();
        idle();
        i_reg1 = 4'd7;
        #1;
        exp_read(7, ed, er);
        total++;
        if (o_data1 !== ed || o_wr_err !== exp_err) begin
            bad++;
            $display("FAIL same_wr7 got d=%0d err=%0b exp d=%0d err=%0b", o_data1, o_wr_err, ed, exp_err);
        end
        i_lock = 4'd7;
        tick();
        i_lock = 4'd7;
        i_reg3 = 4'd7;
        i_data3 = 6'd9;
        tick();
        idle();
        #1;
        exp_read(7, ed, er);
        total++;
        if (o_data1 !== ed || o_rdy1 !== er || o_wr_err !== exp_err || o_busy_cnt !== 4'(exp_cnt)) begin
            bad++;
            $display("FAIL relock7 got d=%0d r=%0b err=%0b cnt=%0d exp d=%0d r=%0b err=%0b cnt=%0d",
                     o_data1, o_rdy1, o_wr_err, o_busy_cnt, ed, er, exp_err, exp_cnt);
        end
        i_reg3 = 4'd7;
        tick();
        idle();
    endtask

    task automatic test_fill();
        for (int a = 1; a <= 11; a++) begin
            i_lock = 4'(a);
            tick();
            total++;
            if (o_busy_cnt !== 4'(exp_cnt)) begin
                bad++;
                $display("FAIL fill_cnt a=%0d got %0d exp %0d", a, o_busy_cnt, exp_cnt);
            end
        end
        i_lock = 4'd4;
        tick();
        total++;
        if (o_wr_err !== exp_err || o_busy_cnt !== 4'(exp_cnt) || exp_cnt != 11) begin
            bad++;
            $display("FAIL double_lock got err=%0b cnt=%0d exp err=%0b cnt=%0d", o_wr_err, o_busy_cnt, exp_err, exp_cnt);
        end
        idle();
        for (int a = 1; a <= 11; a++) begin
            i_reg3 = 4'(a);
            i_data3 = 6'(a);
            tick();
        end
        idle();
        total++;
        if (o_busy_cnt !== 4'(exp_cnt) || exp_cnt != 0) begin
            bad++;
            $display("FAIL drain_cnt got %0d exp %0d", o_busy_cnt, exp_cnt);
        end
    endtask

    task automatic test_bypass();
        logic signed [5:0] ed;
        logic              er;
        i_reg3 = 4'd2;
        i_data3 = 6'(-1);
        i_reg0 = 4'd2;
        #1;
        exp_read(2, ed, er);
        total++;
        if (o_data0 !== ed || o_rdy0 !== er) begin
            bad++;
            $display("FAIL bypass2 got d=%0d r=%0b exp d=%0d r=%0b", o_data0, o_rdy0, ed, er);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        logic signed [5:0] ed;
        logic              er;
        int                a0;
        int                a1;
        for (int n = 0; n < 400; n++) begin
            i_reg2  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            i_reg3  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            i_lock  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            i_data2 = 6'($urandom);
            i_data3 = 6'($urandom);
            a0 = (n % 4 == 0) ? int'(i_reg3) : int'($urandom_range(0, 15));
            a1 = (n % 4 == 1) ? int'(i_reg2) : int'($urandom_range(0, 15));
            i_reg0 = 4'(a0);
            i_reg1 = 4'(a1);
            #1;
            exp_read(a0, ed, er);
            total++;
            if (o_data0 !== ed || o_rdy0 !== er) begin
                bad++;
                $display("FAIL rnd_rd0 n=%0d a=%0d got d=%0d r=%0b exp d=%0d r=%0b", n, a0, o_data0, o_rdy0, ed, er);
            end
            exp_read(a1, ed, er);
            total++;
            if (o_data1 !== ed || o_rdy1 !== er) begin
                bad++;
                $display("FAIL rnd_rd1 n=%0d a=%0d got d=%0d r=%0b exp d=%0d r=%0b", n, a1, o_data1, o_rdy1, ed, er);
            end
            tick();
            total++;
            if (o_wr_err !== exp_err || o_busy_cnt !== 4'(exp_cnt)) begin
                bad++;
                $display("FAIL rnd_seq n=%0d got err=%0b cnt=%0d exp err=%0b cnt=%0d", n, o_wr_err, o_busy_cnt, exp_err, exp_cnt);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        i_reg2 = 4'd9;
        i_data2 = 6'd21;
        i_lock = 4'd6;
        tick();
        idle();
        i_reg0 = 4'd9;
        i_reg1 = 4'd6;
        #1;
        i_rsn = 1'b0;
        model_reset();
        #1;
        total++;
        if (o_data0 !== 6'sd0 || o_rdy1 !== 1'b1 || o_busy_cnt !== 4'd0 || o_wr_err !== 1'b0) begin
            bad++;
            $display("FAIL async_rst got d0=%0d r1=%0b cnt=%0d err=%0b exp 0 1 0 0", o_data0, o_rdy1, o_busy_cnt, o_wr_err);
        end
        @(negedge i_clk);
        i_rsn = 1'b1;
    endtask

    initial begin
        i_reg0 = '0;
        i_reg1 = '0;
        test_reset();
        test_fast_write();
        test_lock();
        test_conflict();
        test_fill();
        test_bypass();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
